// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// traffic_pkg: shared state encoding, lamp codes and road-selection helpers
// Rev 1.0
// ============================================================================
package traffic_pkg;

  localparam int c_max_roads = 16;
  localparam int c_idx_w     = 4;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_EMERG  = 2'd3
  } state_e;

  // Lamp code bit order is {red, yellow, green}.
  localparam logic [2:0] c_lamp_red    = 3'b100;
  localparam logic [2:0] c_lamp_yellow = 3'b010;
  localparam logic [2:0] c_lamp_green  = 3'b001;

  typedef struct packed {
    logic               valid;
    logic [c_idx_w-1:0] idx;
  } pick_t;

  function automatic pick_t lowest_set(input logic [c_max_roads-1:0] vec);
    pick_t r;
    r = '0;
    for (int i = c_max_roads - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = c_idx_w'(i);
      end
    end
    return r;
  endfunction

  // Nearest set index strictly after cur, wrapping within n roads; cur itself is never returned.
  function automatic pick_t next_rr(input logic [c_max_roads-1:0] vec,
                                    input logic [c_idx_w-1:0]     cur,
                                    input int                     n);
    pick_t r;
    int    idx;
    r = '0;
    for (int off = c_max_roads - 1; off >= 1; off--) begin
      if (off < n) begin
        idx = int'(cur) + off;
        if (idx >= n) idx = idx - n;
        if (vec[idx]) begin
          r.valid = 1'b1;
          r.idx   = c_idx_w'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_tick_prescaler.sv
`default_nettype none
// ============================================================================
// traffic_tick_prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr
// Rev 1.0
// ============================================================================
module traffic_tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int                 c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  assign tick = (cnt_q == c_last);

  always_comb begin
    cnt_d = cnt_q + c_cnt_w'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_nway.sv
`default_nettype none
// ============================================================================
// traffic_light_nway: N-road round-robin intersection controller with demand
// skipping, emergency preemption and mandatory yellow/all-red clearance.
// Rev 1.0
// ============================================================================
module traffic_light_nway
  import traffic_pkg::*;
#(
  parameter int NUM_ROADS    = 4,
  parameter int TICK_DIV     = 50000000,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int TMR_W        = 8
) (
  input  logic                         clk_50mhz,
  input  logic                         rst_n,
  input  logic [NUM_ROADS-1:0]         emergency,
  input  logic [NUM_ROADS-1:0]         car_present,
  output logic [NUM_ROADS-1:0]         red,
  output logic [NUM_ROADS-1:0]         yellow,
  output logic [NUM_ROADS-1:0]         green,
  output logic [$clog2(NUM_ROADS)-1:0] active_road,
  output logic                         emerg_active
);

  localparam int               c_aw          = $clog2(NUM_ROADS);
  localparam logic [TMR_W-1:0] c_green_load  = TMR_W'(GREEN_TICKS - 1);
  localparam logic [TMR_W-1:0] c_yellow_load = TMR_W'(YELLOW_TICKS - 1);
  localparam logic [TMR_W-1:0] c_allred_load = TMR_W'(ALLRED_TICKS - 1);

  state_e                 state_q, state_d;
  logic [c_aw-1:0]        active_q, active_d;
  logic [c_aw-1:0]        target_q, target_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_ROADS-1:0]   red_q, yellow_q, green_q;
  logic [NUM_ROADS-1:0]   red_d, yellow_d, green_d;
  logic                   emerg_q;

  logic                   tick;
  logic                   expire;
  logic                   entry;
  logic                   reload;
  logic [c_max_roads-1:0] emerg_ext;
  logic [c_max_roads-1:0] car_ext;
  pick_t                  win_pick;
  pick_t                  rr_pick;
  logic [c_aw-1:0]        win_road;
  logic [c_aw-1:0]        rr_road;
  logic [c_aw-1:0]        inc_road;
  logic                   unused_bits;

  assign emerg_ext = c_max_roads'(emergency);
  assign car_ext   = c_max_roads'(car_present);
  assign win_pick  = lowest_set(emerg_ext);
  assign rr_pick   = next_rr(car_ext, c_idx_w'(active_q), NUM_ROADS);
  assign win_road  = win_pick.idx[c_aw-1:0];
  assign rr_road   = rr_pick.idx[c_aw-1:0];
  assign inc_road  = (active_q == c_aw'(NUM_ROADS - 1)) ? '0 : active_q + c_aw'(1);

  assign unused_bits = ^{win_pick.idx, rr_pick.idx, emerg_ext, car_ext};

  assign expire = tick && (timer_q == '0);
  assign entry  = (state_d != state_q);

  traffic_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .clr       (entry),
    .tick      (tick)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    reload   = 1'b0;
    unique case (state_q)
      S_ALLRED: begin
        if (win_pick.valid) target_d = win_road;
        if (expire) begin
          active_d = target_d;
          state_d  = emergency[target_d] ? S_EMERG : S_GREEN;
        end
      end
      S_GREEN: begin
        // A live emergency request beats timer expiry on the same edge.
        if (win_pick.valid) begin
          if (win_road == active_q) begin
            state_d = S_EMERG;
          end else begin
            state_d  = S_YELLOW;
            target_d = win_road;
          end
        end else if (expire) begin
          if (rr_pick.valid) begin
            state_d  = S_YELLOW;
            target_d = rr_road;
          end else begin
            reload = 1'b1;
          end
        end
      end
      S_YELLOW: begin
        if (win_pick.valid) target_d = win_road;
        if (expire) state_d = S_ALLRED;
      end
      S_EMERG: begin
        if (!emergency[active_q]) begin
          state_d  = S_YELLOW;
          target_d = win_pick.valid ? win_road :
                     rr_pick.valid  ? rr_road  : inc_road;
        end
      end
      default: state_d = S_ALLRED;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (entry) begin
      unique case (state_d)
        S_GREEN:  timer_d = c_green_load;
        S_YELLOW: timer_d = c_yellow_load;
        S_ALLRED: timer_d = c_allred_load;
        default:  timer_d = '0;
      endcase
    end else if (reload) begin
      timer_d = c_green_load;
    end else if (tick && (timer_q != '0)) begin
      timer_d = timer_q - TMR_W'(1);
    end
  end

  // Lamps are decoded from next-state values so they switch on the same edge as the state.
  for (genvar i = 0; i < NUM_ROADS; i++) begin : g_lamp
    logic [2:0] code;
    always_comb begin
      code = c_lamp_red;
      if (active_d == c_aw'(i)) begin
        unique case (state_d)
          S_GREEN, S_EMERG: code = c_lamp_green;
          S_YELLOW:         code = c_lamp_yellow;
          default:          code = c_lamp_red;
        endcase
      end
    end
    assign red_d[i]    = code[2];
    assign yellow_d[i] = code[1];
    assign green_d[i]  = code[0];
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ALLRED;
      active_q <= c_aw'(NUM_ROADS - 1);
      target_q <= '0;
      timer_q  <= c_allred_load;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
      emerg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      emerg_q  <= (state_d == S_EMERG);
    end
  end

  assign red          = red_q;
  assign yellow       = yellow_q;
  assign green        = green_q;
  assign active_road  = active_q;
  assign emerg_active = emerg_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_nway.sv
`default_nettype none
// ============================================================================
// tb_traffic_light_nway: scoreboard bench; a phase-level model predicts the
// lamps each cycle and a monitor compares them against the controller.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_traffic_light_nway;

  localparam int N   = 4;
  localparam int DIV = 2;
  localparam int GT  = 4;
  localparam int YT  = 2;
  localparam int AT  = 1;

  typedef enum int {P_ALLRED, P_GREEN, P_YELLOW, P_EMERG} phase_t;

  logic         clk_50mhz   = 1'b0;
  logic         rst_n       = 1'b0;
  logic [N-1:0] emergency   = '0;
  logic [N-1:0] car_present = '0;
  logic [N-1:0] red, yellow, green;
  logic [1:0]   active_road;
  logic         emerg_active;

  traffic_light_nway #(
    .NUM_ROADS    (N),
    .TICK_DIV     (DIV),
    .GREEN_TICKS  (GT),
    .YELLOW_TICKS (YT),
    .ALLRED_TICKS (AT),
    .TMR_W        (8)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .rst_n        (rst_n),
    .emergency    (emergency),
    .car_present  (car_present),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .active_road  (active_road),
    .emerg_active (emerg_active)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  // Model: current phase, cycles left in it, road holding right-of-way, next road.
  phase_t      m_phase;
  int          m_left;
  int          m_road;
  int          m_tgt;
  logic [14:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  function automatic int winner(input logic [N-1:0] em);
    for (int i = 0; i < N; i++) if (em[i]) return i;
    return -1;
  endfunction

  function automatic int next_car(input logic [N-1:0] car, input int road);
    for (int k = 1; k < N; k++) if (car[(road + k) % N]) return (road + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_ALLRED;
    m_left  = AT * DIV;
    m_road  = N - 1;
    m_tgt   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] em, input logic [N-1:0] car);
    int w, nc;
    w  = winner(em);
    nc = next_car(car, m_road);
    case (m_phase)
      P_ALLRED: begin
        if (w >= 0) m_tgt = w;
        m_left--;
        if (m_left == 0) begin
          m_road = m_tgt;
          if (em[m_tgt]) m_phase = P_EMERG;
          else begin m_phase = P_GREEN; m_left = GT * DIV; end
        end
      end
      P_GREEN: begin
        if (w >= 0) begin
          if (w == m_road) m_phase = P_EMERG;
          else begin m_phase = P_YELLOW; m_left = YT * DIV; m_tgt = w; end
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (nc >= 0) begin m_phase = P_YELLOW; m_left = YT * DIV; m_tgt = nc; end
            else m_left = GT * DIV;
          end
        end
      end
      P_YELLOW: begin
        if (w >= 0) m_tgt = w;
        m_left--;
        if (m_left == 0) begin m_phase = P_ALLRED; m_left = AT * DIV; end
      end
      P_EMERG: begin
        if (!em[m_road]) begin
          m_phase = P_YELLOW;
          m_left  = YT * DIV;
          m_tgt   = (w >= 0) ? w : (nc >= 0) ? nc : (m_road + 1) % N;
        end
      end
      default: model_reset();
    endcase
  endtask

  function automatic logic [14:0] model_out();
    logic [N-1:0] r, y, g;
    r = '1; y = '0; g = '0;
    if (m_phase == P_GREEN || m_phase == P_EMERG) begin
      r[m_road] = 1'b0; g[m_road] = 1'b1;
    end else if (m_phase == P_YELLOW) begin
      r[m_road] = 1'b0; y[m_road] = 1'b1;
    end
    return {r, y, g, 2'(m_road), (m_phase == P_EMERG)};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got r=%b y=%b g=%b act=%0d em=%b, expected r=%b y=%b g=%b act=%0d em=%b",
                  name, cyc, act[14:11], act[10:7], act[6:3], act[2:1], act[0],
                  exp[14:11], exp[10:7], exp[6:3], exp[2:1], exp[0]);
  endtask

  // Monitor: the controller presents a new output every clock.
  initial begin
    logic [14:0] e;
    int          nonred;
    logic        ok;
    forever begin
      @(posedge clk_50mhz);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lamps", {red, yellow, green, active_road, emerg_active}, e);
        ok = 1'b1; nonred = 0;
        for (int i = 0; i < N; i++) begin
          if ($countones({red[i], yellow[i], green[i]}) != 1) ok = 1'b0;
          if (!red[i]) nonred++;
        end
        if (nonred > 1) ok = 1'b0;
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL invariant @cycle %0d: r=%b y=%b g=%b", cyc, red, yellow, green);
      end
    end
  end

  task automatic drive(input logic [N-1:0] em, input logic [N-1:0] car);
    @(negedge clk_50mhz);
    emergency   = em;
    car_present = car;
    if (rst_n) model_step(em, car);
    else model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic release_reset(input logic [N-1:0] car);
    @(negedge clk_50mhz);
    rst_n       = 1'b1;
    emergency   = '0;
    car_present = car;
    model_step('0, car);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int cycles, input logic [N-1:0] em, input logic [N-1:0] car);
    for (int i = 0; i < cycles; i++) drive(em, car);
  endtask

  task automatic run_until(input phase_t ph, input int road, input logic [N-1:0] car,
                           input string name);
    int k;
    k = 0;
    while (!(m_phase == ph && (road < 0 || m_road == road)) && k < 100) begin
      drive('0, car);
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      $display("FAIL %s: wanted phase %0d not reached within 100 cycles, still %0d", name, ph, m_phase);
    end
  endtask

  task automatic async_reset(input logic [N-1:0] car);
    @(negedge clk_50mhz);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {red, yellow, green, active_road, emerg_active},
          {4'hF, 4'h0, 4'h0, 2'd3, 1'b0});
    model_reset();
    run(2, '0, car);
    release_reset(car);
  endtask

  initial begin
    logic [N-1:0] r_em, r_car;
    int           hold;
    model_reset();
    run(3, '0, '0);
    release_reset(4'b1111);
    run(60, '0, 4'b1111);
    run(60, '0, 4'b0101);
    run(30, '0, 4'b0001);
    run_until(P_YELLOW, -1, 4'b1111, "reach_yellow");
    drive('0, 4'b1111);
    async_reset(4'b1111);
    run(4, '0, 4'b1111);
    run(20, 4'b0100, 4'b1111);
    run(30, '0, 4'b1111);
    run_until(P_ALLRED, -1, 4'b1111, "reach_allred");
    run(25, 4'b0110, 4'b1111);
    run(25, 4'b0100, 4'b1111);
    run(20, '0, 4'b1111);
    run_until(P_GREEN, 0, 4'b1111, "reach_road0_green");
    run(10, 4'b0001, 4'b1111);
    run(20, '0, 4'b1111);
    hold = 0; r_em = '0; r_car = '0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        hold  = $urandom_range(1, 40);
        r_car = 4'($urandom);
        r_em  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      hold--;
      if (i == 700) async_reset(r_car);
      else drive(r_em, r_car);
    end
    @(posedge clk_50mhz);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
